store_unit: RTL and testbench

- Store-side companion to the memory stage's load path. Takes one SB/SH/SW request at a time and aligns the store data to the correct byte lane(s).
- The data memory has only a word-wide write enable with no byte enables. Sub-word stores therefore use a read-modify-write sequence; aligned SW writes directly.
- Misaligned addresses and illegal func3 values are reported as faults without touching memory.

---
 rtl/store_unit.sv | 127 ++++++++++++
 tb/tb_store_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// Store unit: aligns SB/SH/SW data to byte lanes. Sub-word stores do a read-modify-write; aligned SW writes directly.
// Latency: fault->resp T+1, SW write T+1/resp T+2, SB/SH read T+1/write T+2/resp T+3. Single outstanding request.
module store_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic [2:0]            req_func3,
  output logic                  resp_valid,
  output logic                  resp_fault,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_en,
  input  logic [31:0]           mem_rdata,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata
);

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic [2:0]            func3_q;
  logic                  fault_q;
  logic                  req_fault;
  logic [31:0]           merged;
  logic [ADDR_WIDTH-1:0] aligned;

  always_comb begin
    case (req_func3)
      F3_SB:   req_fault = 1'b0;
      F3_SH:   req_fault = req_addr[0];
      F3_SW:   req_fault = (req_addr[1:0] != 2'b00);
      default: req_fault = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      func3_q <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            data_q  <= req_data;
            func3_q <= req_func3;
            fault_q <= req_fault;
            if (req_fault)               state <= RESP;
            else if (req_func3 == F3_SW) state <= WRITE;
            else                         state <= READ;
          end
        end
        READ:    state <= MERGE;
        MERGE:   state <= RESP;
        WRITE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign aligned = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  // Replace only the addressed lane(s) of the word read back in READ.
  always_comb begin
    merged = mem_rdata;
    if (func3_q == F3_SB) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = data_q[7:0];
        2'd1:    merged[15:8]  = data_q[7:0];
        2'd2:    merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = data_q[15:0];
    end else begin
      merged[15:0] = data_q[15:0];
    end
  end

  // Strobes are gated by reset_n so nothing fires while reset is held mid-operation.
  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_fault  = 1'b0;
    mem_addr    = '0;
    mem_read_en = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    case (state)
      IDLE: req_ready = reset_n;
      READ: begin
        mem_read_en = reset_n;
        mem_addr    = aligned;
      end
      MERGE: begin
        mem_we    = reset_n;
        mem_addr  = aligned;
        mem_wdata = merged;
      end
      WRITE: begin
        mem_we    = reset_n;
        mem_addr  = aligned;
        mem_wdata = data_q;
      end
      RESP: begin
        resp_valid = reset_n;
        resp_fault = reset_n & fault_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: transaction-level model predicts every cycle's outputs; literal memory words pin the model.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic [2:0]  req_func3 = '0;
  logic        resp_valid;
  logic        resp_fault;
  logic [9:0]  mem_addr;
  logic        mem_read_en;
  logic [31:0] mem_rdata = '0;
  logic        mem_we;
  logic [31:0] mem_wdata;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;

  bit [31:0] mem [256];
  bit [31:0] shadow [256];
  logic       pre_en = 1'b0;
  logic [7:0] pre_idx = '0;
  logic [31:0] pre_val = '0;

  typedef struct packed {
    logic        rd;
    logic        we;
    logic        resp;
    logic        flt;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } rec_t;

  rec_t q[$];
  rec_t model_r;
  rec_t exp_r;

  store_unit #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_func3(req_func3),
    .resp_valid(resp_valid), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Word-wide memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_read_en) mem_rdata <= mem[mem_addr[9:2]];
    if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
    if (pre_en) mem[pre_idx] = pre_val;
  end

  // Expected per-cycle outputs for one accepted request, from the store rules.
  task automatic accept(input logic [9:0] a, input logic [31:0] d, input logic [2:0] f);
    logic [9:0]  al;
    logic        flt;
    logic [31:0] old, mask, nw;
    int          sh;
    rec_t        r;
    al  = {a[9:2], 2'b00};
    flt = (f == 3'd1 && a[0]) || (f == 3'd2 && a[1:0] != 2'b00) || (f > 3'd2);
    acc_cnt++;
    if (!flt && f == 3'd2) begin
      r = '0; r.we = 1'b1; r.addr = al; r.wdata = d; q.push_back(r);
    end else if (!flt) begin
      old = shadow[a[9:2]];
      if (f == 3'd0) begin sh = 8 * int'(a[1:0]); mask = 32'h0000_00FF << sh; end
      else           begin sh = 16 * int'(a[1]);  mask = 32'h0000_FFFF << sh; end
      nw = (old & ~mask) | ((d << sh) & mask);
      r = '0; r.rd = 1'b1; r.addr = al; q.push_back(r);
      r = '0; r.we = 1'b1; r.addr = al; r.wdata = nw; q.push_back(r);
    end
    r = '0; r.resp = 1'b1; r.flt = flt; q.push_back(r);
  endtask

  always @(posedge clk) begin
    if (!reset_n) q.delete();
    else if (q.size() > 0) begin
      model_r = q.pop_front();
      if (model_r.we) shadow[model_r.addr[9:2]] = model_r.wdata;
    end else if (req_valid) accept(req_addr, req_data, req_func3);
    if (pre_en) shadow[pre_idx] = pre_val;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_mem_read_en", 32'(mem_read_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    end else begin
      exp_r = (q.size() == 0) ? rec_t'('0) : q[0];
      chk("req_ready", 32'(req_ready), 32'(q.size() == 0));
      chk("mem_read_en", 32'(mem_read_en), 32'(exp_r.rd));
      chk("mem_we", 32'(mem_we), 32'(exp_r.we));
      chk("resp_valid", 32'(resp_valid), 32'(exp_r.resp));
      chk("resp_fault", 32'(resp_fault), 32'(exp_r.flt));
      chk("mem_addr", 32'(mem_addr), 32'(exp_r.addr));
      chk("mem_wdata", mem_wdata, exp_r.wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic wait_acc(input int n0, input string nm);
    for (int i = 0; i < 20 && acc_cnt == n0; i++) tick();
    if (acc_cnt == n0) begin
      errors++;
      $display("FAIL %s: request not accepted within 20 cycles", nm);
    end
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: operation not finished within 20 cycles", nm);
    end
  endtask

  task automatic do_store(input logic [9:0] a, input logic [31:0] d, input logic [2:0] f, input string nm);
    int n0;
    n0 = acc_cnt;
    req_addr = a; req_data = d; req_func3 = f; req_valid = 1'b1;
    wait_acc(n0, nm);
    req_valid = 1'b0;
    req_addr = 10'h3FF; req_data = 32'hCAFE_F00D; req_func3 = 3'd0;
    wait_idle(nm);
  endtask

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [2:0]  f3;
    logic [31:0] exp_word;
  } vec_t;

  vec_t rmw_vecs[9] = '{
    '{10'h012, 32'h1234_56AA, 3'd0, 32'h11AA_3344},
    '{10'h010, 32'h1234_56AA, 3'd0, 32'h1122_33AA},
    '{10'h011, 32'h1234_56AA, 3'd0, 32'h1122_AA44},
    '{10'h013, 32'h1234_56AA, 3'd0, 32'hAA22_3344},
    '{10'h012, 32'hFFFF_5566, 3'd1, 32'h5566_3344},
    '{10'h010, 32'hFFFF_5566, 3'd1, 32'h1122_5566},
    '{10'h013, 32'hFFFF_5566, 3'd1, 32'h1122_3344},
    '{10'h012, 32'hFFFF_5566, 3'd2, 32'h1122_3344},
    '{10'h010, 32'hFFFF_5566, 3'd4, 32'h1122_3344}
  };

  initial begin
    int n0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    do_store(10'h010, 32'hDEAD_BEEF, 3'd2, "sw_aligned");
    chk("sw_word", mem[4], 32'hDEAD_BEEF);

    foreach (rmw_vecs[i]) begin
      preload(8'd4, 32'h1122_3344);
      do_store(rmw_vecs[i].addr, rmw_vecs[i].data, rmw_vecs[i].f3, "rmw_or_fault");
      chk("rmw_word", mem[4], rmw_vecs[i].exp_word);
    end

    // Back-to-back with req_valid held; request fields churn while busy.
    n0 = acc_cnt;
    req_addr = 10'h020; req_data = 32'hAAAA_0001; req_func3 = 3'd2; req_valid = 1'b1;
    wait_acc(n0, "b2b_first");
    req_addr = 10'h3FD; req_data = 32'h0BAD_0BAD; req_func3 = 3'd0;
    tick();
    req_addr = 10'h024; req_data = 32'hBBBB_0002; req_func3 = 3'd2;
    wait_acc(n0 + 1, "b2b_second");
    req_valid = 1'b0;
    wait_idle("b2b");
    chk("b2b_word0", mem[8], 32'hAAAA_0001);
    chk("b2b_word1", mem[9], 32'hBBBB_0002);
    chk("b2b_untouched", mem[255], 32'h0000_0000);

    // Reset asserted during the MERGE cycle abandons the store.
    preload(8'd12, 32'h1122_3344);
    n0 = acc_cnt;
    req_addr = 10'h030; req_data = 32'h0000_0077; req_func3 = 3'd0; req_valid = 1'b1;
    wait_acc(n0, "rst_midop");
    req_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("rst_word", mem[12], 32'h1122_3344);
    chk("rst_prior_write", mem[4], 32'h1122_3344);

    do_store(10'h032, 32'h0000_9988, 3'd1, "post_reset_sh");
    chk("post_reset_word", mem[12], 32'h9988_3344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
